// File: rtl/comp_pkg.sv
// Shared constants and types for the comparator event qualifier.
// Imported by comp_evt_chan and comp_evt.
package comp_pkg;

    // Default width of the qualification threshold and run counters
    localparam int FLT_W_DEF = 4;

    // Width of the saturating qualified-event counters
    localparam int EVT_W = 8;

    // Channel indices
    localparam int CH_LOW  = 0;
    localparam int CH_HIGH = 1;
    localparam int NUM_CH  = 2;

    // Per-channel flag state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SET  = 1'b1
    } chan_state_e;

endpackage

// File: rtl/comp_evt_chan.sv
// One comparator channel: consecutive-sample run counter, flag state machine
// and saturating qualified-event counter.
// Optional feature: define COMP_EVT_FILT_EN to include the consecutive-sample
// filter; without it every update with the condition true is an event.
module comp_evt_chan
    import comp_pkg::*;
#(
    parameter int FLT_W = FLT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd,
    input  logic             cond,
    input  logic             hw_clr_en,
    input  logic             sw_clr,
    input  logic [FLT_W-1:0] flt_cnt,
    output logic             flg,
    output logic [EVT_W-1:0] evt_cnt,
    output logic             rise
);

    chan_state_e      state_q, state_d;
    logic [EVT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             qual;

    // Flag state: a qualified event wins over any clear arriving with it
    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (qual) begin
            state_d = ST_SET;
        end else if (state_q == ST_SET &&
                     (sw_clr || (hw_clr_en && upd && !cond))) begin
            state_d = ST_IDLE;
        end
        rise_d = (state_q == ST_IDLE) && (state_d == ST_SET);
    end

    // Event counter: saturating increment, sw clear, increment wins over clear
    always_comb begin
        cnt_d = cnt_q;
        if (qual) begin
            if (sw_clr) begin
                cnt_d = EVT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + EVT_W'(1);
            end
        end else if (sw_clr) begin
            cnt_d = '0;
        end
    end

    // Flag, counter and rise-pulse registers with synchronous reset
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

`ifdef COMP_EVT_FILT_EN
    logic [FLT_W-1:0] run_q, run_d;
    logic [FLT_W-1:0] thr_m1;

    // Run counter: qualify when the pre-increment count equals threshold-1
    always_comb begin
        thr_m1 = (flt_cnt == '0) ? '0 : flt_cnt - FLT_W'(1);
        run_d  = run_q;
        qual   = 1'b0;
        if (upd) begin
            if (cond) begin
                qual = (run_q == thr_m1);
                if (run_q != '1) begin
                    run_d = run_q + FLT_W'(1);
                end
            end else begin
                run_d = '0;
            end
        end
    end

    // Run counter register; reset discards any partial qualification
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end
`else
    // Without the filter every true sample is an event
    always_comb begin
        qual = upd && cond;
    end

    logic unused_flt;
    assign unused_flt = ^flt_cnt;
`endif

    assign flg     = (state_q == ST_SET);
    assign evt_cnt = cnt_q;
    assign rise    = rise_q;

endmodule

// File: rtl/comp_evt.sv
// Comparator event qualifier top: two independent channels (low / high)
// and a merged one-cycle interrupt pulse.
// Optional feature: define COMP_EVT_FILT_EN to include the consecutive-sample
// filter in each channel.
module comp_evt
    import comp_pkg::*;
#(
    parameter int FLT_W = FLT_W_DEF
) (
    input  logic             SYSCLK,
    input  logic             SYSRSTn,
    input  logic             comp_data_update,
    input  logic             comp_data_low,
    input  logic             comp_data_high,
    input  logic             reg_compilen,
    input  logic             reg_compihen,
    input  logic             reg_complclrflg,
    input  logic             reg_comphclrflg,
    input  logic [FLT_W-1:0] reg_compfltcnt,
    input  logic             sw_clr_low,
    input  logic             sw_clr_high,
    output logic             flg_low,
    output logic             flg_high,
    output logic [EVT_W-1:0] evt_cnt_low,
    output logic [EVT_W-1:0] evt_cnt_high,
    output logic             irq
);

    logic [NUM_CH-1:0] cond, hw_clr, sw_clr, en, flg, rise;
    logic [EVT_W-1:0]  cnt [NUM_CH];
    logic              irq_q, irq_d;

    assign cond[CH_LOW]    = comp_data_low;
    assign cond[CH_HIGH]   = comp_data_high;
    assign hw_clr[CH_LOW]  = reg_complclrflg;
    assign hw_clr[CH_HIGH] = reg_comphclrflg;
    assign sw_clr[CH_LOW]  = sw_clr_low;
    assign sw_clr[CH_HIGH] = sw_clr_high;
    assign en[CH_LOW]      = reg_compilen;
    assign en[CH_HIGH]     = reg_compihen;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        comp_evt_chan #(.FLT_W(FLT_W)) u_chan (
            .clk       (SYSCLK),
            .rst_n     (SYSRSTn),
            .upd       (comp_data_update),
            .cond      (cond[c]),
            .hw_clr_en (hw_clr[c]),
            .sw_clr    (sw_clr[c]),
            .flt_cnt   (reg_compfltcnt),
            .flg       (flg[c]),
            .evt_cnt   (cnt[c]),
            .rise      (rise[c])
        );
    end

    // Merge enabled flag rises into a single interrupt request
    always_comb begin
        irq_d = |(rise & en);
    end

    // Interrupt pulse register
    always_ff @(posedge SYSCLK) begin
        if (!SYSRSTn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign flg_low      = flg[CH_LOW];
    assign flg_high     = flg[CH_HIGH];
    assign evt_cnt_low  = cnt[CH_LOW];
    assign evt_cnt_high = cnt[CH_HIGH];
    assign irq          = irq_q;

endmodule
